// File: rtl/conv3x3_sram_engine.sv
// conv3x3_sram_engine: 3x3 shift-weighted SRAM filter, 11 cycles/pixel; CONV3X3_BORDER_CLAMP_EN adds clamped border pixels
module conv3x3_sram_engine #(
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  parameter int DW = 16,
  parameter int AW = 19,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 262144
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  output logic          busy,
  output logic          done,
  output logic          mem_csn,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int ACW = DW + 4;
`ifdef CONV3X3_BORDER_CLAMP_EN
  localparam int LO = 0;
  localparam int XHI = IMG_W - 1;
  localparam int YHI = IMG_H - 1;
`else
  localparam int LO = 1;
  localparam int XHI = IMG_W - 2;
  localparam int YHI = IMG_H - 2;
`endif
  typedef enum logic [2:0] {IDLE, READ, ACC, WRITE, DONE} state_t;
  state_t state;
  logic [1:0] mode_q;
  logic [3:0] tap, rt;
  logic [XW-1:0] x, nx;
  logic [YW-1:0] y, ny;
  logic [ACW-1:0] acc, term, acc_nxt;
  logic [1:0] sh;
  logic [2:0] rsh;
  logic en, last_x, last;
  logic [DW-1:0] res;
  function automatic logic [AW-1:0] tap_addr(input int px, input int py, input int k);
    int tx, ty;
    tx = px + k % 3 - 1;
    ty = py + k / 3 - 1;
`ifdef CONV3X3_BORDER_CLAMP_EN
    tx = tx < 0 ? 0 : tx > IMG_W - 1 ? IMG_W - 1 : tx;
    ty = ty < 0 ? 0 : ty > IMG_H - 1 ? IMG_H - 1 : ty;
`endif
    return AW'(SRC_BASE + ty * IMG_W + tx);
  endfunction
  // rdata always belongs to the tap addressed one cycle earlier
  always_comb begin
    rt = state == ACC ? 4'd8 : tap - 4'd1;
    en = mode_q == 2'd0 || rt == 4'd4 || (mode_q == 2'd1 && (rt == 4'd3 || rt == 4'd5))
      || (mode_q == 2'd2 && (rt == 4'd1 || rt == 4'd7));
    sh = mode_q == 2'd0 ? (rt == 4'd4 ? 2'd2 : {1'b0, rt[0]})
       : (mode_q != 2'd3 && rt == 4'd4) ? 2'd1 : 2'd0;
    rsh = mode_q == 2'd0 ? 3'd4 : mode_q == 2'd3 ? 3'd0 : 3'd2;
    term = en ? ACW'(mem_rdata) << sh : '0;
    acc_nxt = acc + term;
    res = DW'(acc_nxt >> rsh);
    last_x = int'(x) == XHI;
    last = last_x && int'(y) == YHI;
    nx = last_x ? XW'(LO) : x + XW'(1);
    ny = last_x ? y + YW'(1) : y;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      mem_csn <= 1'b1;
      mem_wen <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      acc <= '0;
      x <= '0;
      y <= '0;
      tap <= '0;
      mode_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mode_q <= mode;
          x <= XW'(LO);
          y <= YW'(LO);
          busy <= 1'b1;
          tap <= '0;
          mem_csn <= 1'b0;
          mem_addr <= tap_addr(LO, LO, 0);
          state <= READ;
        end
        READ: begin
          acc <= tap == 4'd0 ? '0 : acc_nxt;
          if (tap == 4'd8) begin
            mem_csn <= 1'b1;
            state <= ACC;
          end else begin
            tap <= tap + 4'd1;
            mem_addr <= tap_addr(int'(x), int'(y), int'(tap) + 1);
          end
        end
        ACC: begin
          acc <= acc_nxt;
          mem_csn <= 1'b0;
          mem_wen <= 1'b1;
          mem_addr <= AW'(DST_BASE + int'(y) * IMG_W + int'(x));
          mem_wdata <= res;
          out_data <= res;
          out_valid <= 1'b1;
          state <= WRITE;
        end
        WRITE: begin
          mem_wen <= 1'b0;
          out_valid <= 1'b0;
          if (last) begin
            mem_csn <= 1'b1;
            busy <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end else begin
            x <= nx;
            y <= ny;
            tap <= '0;
            mem_addr <= tap_addr(int'(nx), int'(ny), 0);
            state <= READ;
          end
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/conv3x3_sram_engine.md
Name: conv3x3_sram_engine

Overview:
- Parametrised successor to the fixed 512x512 Gaussian SRAM filter.
- Walks a source image held in single-port SRAM and computes a 3x3 shift-weighted filter per pixel.
- Writes each result back to a destination region of the same SRAM at the same (x,y) position and mirrors it on a streaming output.
- Image size, data width, address map and kernel mode are selectable; start/busy/done handshake.

Parameters:
IMG_W, 512, image width in pixels (>=3)
IMG_H, 512, image height in pixels (>=3)
DW, 16, pixel/data width
AW, 19, SRAM address width
SRC_BASE, 0, word address of source pixel (0,0)
DST_BASE, 262144, word address of destination pixel (0,0)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-low reset
start  input  1  begin a frame; sampled only in IDLE
mode  input  2  kernel select, latched at accepted start
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse after last write
mem_csn  output  1  SRAM chip select, active low
mem_wen  output  1  SRAM write enable, 1=write
mem_addr  output  AW  SRAM address
mem_wdata  output  DW  SRAM write data
mem_rdata  input  DW  SRAM read data, valid 1 cycle after address
out_valid  output  1  result strobe, coincident with write
out_data  output  DW  result value

Behaviour:
- Reset (rst=0 at edge): state IDLE; busy=0, done=0, mem_csn=1, mem_wen=0, mem_addr=0, mem_wdata=0, out_valid=0, out_data=0, accumulator and x/y counters cleared. Reset mid-frame aborts immediately; no further reads or writes.
- States: IDLE -> READ (taps 0..8) -> ACC -> WRITE -> READ (next pixel) or DONE -> IDLE.
- IDLE: mem_csn=1. start=1 latches mode, sets x=1, y=1 and busy=1, then enters READ next cycle.
- READ: tap k (row-major, k=0 is (x-1,y-1), k=8 is (x+1,y+1)). Drives mem_csn=0, mem_wen=0, mem_addr=SRC_BASE+(y+dy)*IMG_W+(x+dx). rdata of tap k-1 is accumulated in the same cycle; at tap 0 the accumulator is cleared.
- ACC (1 cycle): mem_csn=1; accumulates tap 8.
- WRITE (1 cycle): mem_csn=0, mem_wen=1, mem_addr=DST_BASE+y*IMG_W+x, mem_wdata=out_data=acc>>shift. out_valid=1 this cycle only.
- Fixed 11 cycles per pixel. All 9 taps are read in every mode.
- Scan order: x=1..IMG_W-2, then y++ with x reset to 1. After the write of (IMG_W-2, IMG_H-2), enter DONE.
- DONE: done=1 and busy=0 for 1 cycle, then IDLE.
- Kernel weights and shift by mode:
  - 00 Gaussian: 1 2 1 / 2 4 2 / 1 2 1, shift 4.
  - 01 horizontal: centre row 1 2 1, others 0, shift 2.
  - 10 vertical: centre column 1 2 1, others 0, shift 2.
  - 11 copy: centre weight 1, shift 0.
- Weights are implemented as left shifts. Accumulator is DW+4 bits (no overflow). Result is truncated to the low DW bits after the right shift; it always fits.
- start while busy is ignored. mode changes mid-frame have no effect.
- Frame start/end: start pulse accepted at edge t means the first read is at t+1. The last write is at t+11*P, where P=(IMG_W-2)*(IMG_H-2). done is high at t+11*P+1.

Optional Feature:
- Macro: CONV3X3_BORDER_CLAMP_EN.
- Defined: all pixels are processed, x=0..IMG_W-1 and y=0..IMG_H-1, so P=IMG_W*IMG_H. Tap coordinates are clamped to [0,IMG_W-1] and [0,IMG_H-1] (edge replication).
- Undefined: interior pixels only, as above. Border destination words are never written.

Test Plan:
- Reset: IMG 8x8, hold rst=0 for 3 cycles, then release -> busy=0, done=0, mem_csn=1, mem_wen=0, out_valid=0.
- Constant frame: 8x8, all pixels 100, mode=00, start at t -> 36 writes, each value 100 at DST_BASE+y*8+x for x,y in 1..6; done pulse at t+397.
- Impulse: 16 at (3,3), all others 0, mode=00 -> (3,3)=4; (2,3),(4,3),(3,2),(3,4)=2; the four diagonal neighbours=1; all other outputs 0.
- Copy and directional modes: src(x,y)=8*y+x, mode=11 -> dst(x,y)=8*y+x for the interior. mode=01 with a horizontal ramp -> dst equals src.
- Handshake and abort: start pulsed while busy -> ignored, still 36 writes. rst=0 during the 5th pixel -> no writes after reset; a fresh start completes a full frame.
- CONV3X3_BORDER_CLAMP_EN defined, 8x8 all 100 -> 64 writes including (0,0)=100 and (7,7)=100; done at t+11*64+1.
